// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: default widths,
// memory depth and the controller state encoding.
package data_mem_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_LEN_W  = 3;
    localparam int MEM_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_WAIT  = 3'd1,
        WR_DRIVE = 3'd2,
        RD_DRIVE = 3'd3,
        RD_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/data_mem_ctrl.sv
// Initiator-side controller for the 8x16 data memory. Accepts single or
// burst load/store requests, sequences one memory strobe per word and
// returns load data on a registered valid/ready stream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. req_ready, wr_ready and rd_valid are decoded from state
// only, so a producer may hold valid high for as long as it likes and a
// consumer may hold ready low indefinitely; nothing times out.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              sig_mem_write,
    output logic              sig_mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [2:0]        dbg_state
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [LEN_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rd_data;
    logic                w_last;

    // Last word of the burst when the remaining-count register hits zero.
    assign w_last = (r_count == '0);

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (req_valid) w_next_state = req_write ? WR_WAIT : RD_DRIVE;
            WR_WAIT:  if (wr_valid)  w_next_state = WR_DRIVE;
            WR_DRIVE: w_next_state = w_last ? DONE : WR_WAIT;
            RD_DRIVE: w_next_state = RD_HOLD;
            RD_HOLD:  if (rd_ready)  w_next_state = w_last ? DONE : RD_DRIVE;
            DONE:     w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Address/count, store-data and load-data registers; the address wraps
    // naturally at ADDR_W bits, so bursts past the top restart at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr <= '0;
            r_count    <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_cur_addr <= req_addr;
                        r_count    <= req_len;
                    end
                end
                WR_WAIT: begin
                    if (wr_valid) r_wdata <= wr_data;
                end
                WR_DRIVE: begin
                    if (!w_last) begin
                        r_cur_addr <= r_cur_addr + ADDR_W'(1);
                        r_count    <= r_count - LEN_W'(1);
                    end
                end
                RD_DRIVE: begin
                    r_rd_data <= mem_read_data;
                end
                RD_HOLD: begin
                    if (rd_ready && !w_last) begin
                        r_cur_addr <= r_cur_addr + ADDR_W'(1);
                        r_count    <= r_count - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore output decode: strobes and handshake flags depend on state only,
    // apart from req_ready which is also held low while reset is asserted.
    always_comb begin
        req_ready     = 1'b0;
        wr_ready      = 1'b0;
        rd_valid      = 1'b0;
        done          = 1'b0;
        sig_mem_write = 1'b0;
        sig_mem_read  = 1'b0;
        busy          = (r_state != IDLE);
        case (r_state)
            IDLE:     req_ready     = !rst;
            WR_WAIT:  wr_ready      = 1'b1;
            WR_DRIVE: sig_mem_write = 1'b1;
            RD_DRIVE: sig_mem_read  = 1'b1;
            RD_HOLD:  rd_valid      = 1'b1;
            DONE:     done          = 1'b1;
            default: begin
            end
        endcase
    end

    assign mem_addr       = r_cur_addr;
    assign mem_write_data = r_wdata;
    assign rd_data        = r_rd_data;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, hand-written reset and
// backpressure sequences, and randomized bursts against a word-level model
// of the memory contents.
module tb_data_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int LW = 3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic          sig_mem_write, sig_mem_read;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    data_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .sig_mem_write(sig_mem_write), .sig_mem_read(sig_mem_read),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .dbg_state(dbg_state)
    );

    // Memory the controller talks to (combinational read, clocked write).
    logic [DW-1:0] env_mem [8];
    assign mem_read_data = env_mem[mem_addr];
    always @(posedge clk) if (sig_mem_write) env_mem[mem_addr] <= mem_write_data;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0]    ref_mem [8];     // expected memory contents
    logic [DW-1:0]    exp_q [$];       // expected load words, in order
    logic [AW+DW-1:0] exp_wr_q [$];    // expected {addr, data} per write strobe
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int wr_strobes = 0, rd_strobes = 0, done_cnt = 0;
    bit prev_wr = 0, prev_rd = 0;
    bit mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: strobe exclusivity, one-cycle pulses, write scoreboard,
    // no request acceptance while busy.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (sig_mem_write || sig_mem_read)
                chk("strobe_excl", 32'(sig_mem_write & sig_mem_read), 32'd0);
            if (sig_mem_write) begin
                chk("wr_pulse_len", 32'(prev_wr), 32'd0);
                if (exp_wr_q.size() > 0) begin
                    logic [AW+DW-1:0] e;
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
                    chk("wr_data", 32'(mem_write_data), 32'(e[DW-1:0]));
                end else begin
                    fail_now("wr_unexpected");
                end
            end
            if (sig_mem_read) chk("rd_pulse_len", 32'(prev_rd), 32'd0);
            if (busy) chk("req_ready_busy", 32'(req_ready), 32'd0);
        end
        prev_wr <= sig_mem_write;
        prev_rd <= sig_mem_read;
        if (sig_mem_write) wr_strobes <= wr_strobes + 1;
        if (sig_mem_read)  rd_strobes <= rd_strobes + 1;
        if (done)          done_cnt   <= done_cnt + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_ready();
        int n = 0;
        while (!req_ready && n < 60) begin tick(); n++; end
        if (!req_ready) fail_now("req_ready_timeout");
    endtask

    task automatic wait_wr_ready();
        int n = 0;
        while (!wr_ready && n < 60) begin tick(); n++; end
        if (!wr_ready) fail_now("wr_ready_timeout");
    endtask

    task automatic wait_rd_valid();
        int n = 0;
        while (!rd_valid && n < 60) begin tick(); n++; end
        if (!rd_valid) fail_now("rd_valid_timeout");
    endtask

    task automatic send_req(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l,
                            output int acc);
        wait_req_ready();
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        tick();
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic store_words(input logic [AW-1:0] a, input logic [LW-1:0] l,
                               input logic [DW-1:0] d0, input int gap, input bit rnd);
        for (int i = 0; i <= int'(l); i++) begin
            logic [AW-1:0] ad;
            logic [DW-1:0] d;
            int g;
            ad = a + AW'(i);
            d  = rnd ? DW'($urandom) : d0 + DW'(i);
            g  = rnd ? int'($urandom_range(0, 3)) : gap;
            wait_wr_ready();
            repeat (g) tick();
            wr_valid = 1'b1;
            wr_data  = d;
            exp_wr_q.push_back({ad, d});
            ref_mem[ad] = d;
            tick();
            wr_valid = 1'b0;
        end
    endtask

    task automatic load_words(input logic [LW-1:0] l, input int bp, input bit rnd);
        for (int i = 0; i <= int'(l); i++) begin
            logic [DW-1:0] e;
            int b, s;
            wait_rd_valid();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("rd_data", 32'(rd_data), 32'(e));
            b = rnd ? int'($urandom_range(0, 3)) : bp;
            s = rd_strobes;
            for (int k = 0; k < b; k++) begin
                tick();
                chk("bp_rd_valid", 32'(rd_valid), 32'd1);
                chk("bp_rd_data", 32'(rd_data), 32'(e));
            end
            if (b > 0) chk("bp_no_extra_read", 32'(rd_strobes - s), 32'd0);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
    endtask

    // One complete burst: model update, drive, latency, strobe counts, done.
    task automatic run_txn(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [DW-1:0] d0, input int gap, input int bp,
                           input bit rnd, input int exp_lat);
        int acc, ws, rs, dc, n;
        ws = wr_strobes;
        rs = rd_strobes;
        dc = done_cnt;
        if (!w)
            for (int i = 0; i <= int'(l); i++) exp_q.push_back(ref_mem[a + AW'(i)]);
        send_req(w, a, l, acc);
        if (w) store_words(a, l, d0, gap, rnd);
        else   load_words(l, bp, rnd);
        n = 0;
        while (!done && n < 60) begin tick(); n++; end
        if (!done) fail_now("done_timeout");
        if (exp_lat != 0) chk("done_latency", 32'(cyc - acc + 1), 32'(exp_lat));
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("req_ready_after", 32'(req_ready), 32'd1);
        chk("wr_strobe_count", 32'(wr_strobes - ws), w ? 32'(l) + 1 : 32'd0);
        chk("rd_strobe_count", 32'(rd_strobes - rs), w ? 32'd0 : 32'(l) + 1);
        chk("done_count", 32'(done_cnt - dc), 32'd1);
    endtask

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [LW-1:0] l;
        logic [DW-1:0] d0;
        int            gap;
        int            bp;
        int            exp_lat;   // cycle of done, counting the accept edge as 0; 0 = not checked
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            env_mem[i] <= v;
            ref_mem[i] = v;
        end
        rst = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;

        // Reset state, sampled while rst is still high.
        tick(); tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_strobes", 32'({sig_mem_write, sig_mem_read}), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_write_data), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        // Directed vector table.
        vecs[0] = '{1'b1, 3'd3, 3'd0, 16'hA5A5, 0, 0, 3};   // single store
        vecs[1] = '{1'b0, 3'd3, 3'd0, 16'h0,    0, 0, 3};   // single load of it
        vecs[2] = '{1'b1, 3'd6, 3'd3, 16'h0001, 2, 0, 0};   // wrapping store, gaps
        vecs[3] = '{1'b0, 3'd6, 3'd3, 16'h0,    0, 0, 9};   // wrapping load 1..4
        vecs[4] = '{1'b0, 3'd3, 3'd0, 16'h0,    0, 5, 0};   // 5-cycle backpressure
        vecs[5] = '{1'b1, 3'd0, 3'd7, 16'h0100, 0, 0, 17};  // full-depth store
        vecs[6] = '{1'b0, 3'd5, 3'd7, 16'h0,    0, 0, 17};  // full-depth wrapping load
        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].w, vecs[i].a, vecs[i].l, vecs[i].d0,
                    vecs[i].gap, vecs[i].bp, 1'b0, vecs[i].exp_lat);
        chk("ref_addr7", 32'(ref_mem[7]), 32'h0107);

        // Reset during WR_WAIT of word 2, with a request offered while busy.
        begin
            int acc, dc, ws;
            send_req(1'b1, 3'd2, 3'd3, acc);
            wait_wr_ready();
            wr_valid = 1'b1;
            wr_data  = 16'hBEEF;
            exp_wr_q.push_back({3'd2, 16'hBEEF});
            ref_mem[2] = 16'hBEEF;
            tick();
            wr_valid  = 1'b0;
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 3'd1;
            req_len   = 3'd0;
            tick();
            chk("abort_in_wr_wait", 32'(wr_ready), 32'd1);
            tick(); tick();
            chk("busy_req_ignored", 32'(wr_ready), 32'd1);
            dc = done_cnt;
            ws = wr_strobes;
            req_valid = 1'b0;
            rst = 1'b1;
            tick();
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_req_ready_in_rst", 32'(req_ready), 32'd0);
            chk("abort_strobes", 32'({sig_mem_write, sig_mem_read}), 32'd0);
            chk("abort_wr_ready", 32'(wr_ready), 32'd0);
            chk("abort_mem_addr", 32'(mem_addr), 32'd0);
            chk("abort_wdata", 32'(mem_write_data), 32'd0);
            chk("abort_rd_data", 32'(rd_data), 32'd0);
            rst = 1'b0;
            #1;
            chk("abort_req_ready", 32'(req_ready), 32'd1);
            repeat (4) tick();
            chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
            chk("abort_no_strobe", 32'(wr_strobes - ws), 32'd0);
            chk("abort_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        end

        // Randomized bursts against the word-level model.
        for (int t = 0; t < 30; t++) begin
            bit            w;
            logic [AW-1:0] a;
            logic [LW-1:0] l;
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 7));
            l = LW'($urandom_range(0, 7));
            run_txn(w, a, l, 16'h0, 0, 0, 1'b1, 0);
        end
        // Read everything back once so every written word is checked.
        run_txn(1'b0, 3'd0, 3'd7, 16'h0, 0, 0, 1'b0, 17);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("exp_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Initiator-side controller for the 8x16 data memory.
- Takes single or burst load/store requests from the datapath and sequences the memory strobes (sig_mem_write, sig_mem_read), address and write data.
- Captures read data and returns it over a valid/ready stream.
- Guarantees the memory never sees read and write asserted together, and never sees an undriven address.

Parameters:
- DATA_W, 16, data word width; must equal the memory word width.
- ADDR_W, 3, word address width; memory depth is 2^ADDR_W = 8.
- LEN_W, 3, burst length field width; a burst moves req_len+1 words, 1..8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  controller can accept a request (IDLE only).
- req_write  in  1  1 = store burst, 0 = load burst.
- req_addr  in  ADDR_W  start word address.
- req_len  in  LEN_W  words minus one.
- wr_valid  in  1  store data word offered.
- wr_ready  out  1  controller accepts a store word.
- wr_data  in  DATA_W  store data word.
- rd_valid  out  1  load data word available.
- rd_ready  in  1  consumer accepts the load word.
- rd_data  out  DATA_W  load data word, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- sig_mem_write  out  1  memory write strobe.
- sig_mem_read  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_write_data  out  DATA_W  memory write data.
- mem_read_data  in  DATA_W  memory read data; combinational, valid in the same cycle as sig_mem_read.

Behaviour:
- Reset (synchronous, active-high): the cycle after rst is sampled high, state=IDLE and all outputs are 0, except req_ready=0 while rst is high and 1 after it.
  - Internal registers cleared: cur_addr=0, count=0, wdata_reg=0, rd_data=0.
  - Reset mid-burst aborts the burst immediately; no done pulse; no further strobes.
- Strobes are Moore outputs decoded from state only; they never glitch on inputs.
  - mem_addr = cur_addr.
  - mem_write_data = wdata_reg.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready: cur_addr<=req_addr, count<=req_len, then WR_WAIT if req_write else RD_DRIVE.
  - WR_WAIT: wr_ready=1. On wr_valid: wdata_reg<=wr_data, go to WR_DRIVE. Otherwise hold, with no timeout.
  - WR_DRIVE: sig_mem_write=1 for exactly one cycle. If count==0 go to DONE; else cur_addr<=cur_addr+1, count<=count-1, go to WR_WAIT.
  - RD_DRIVE: sig_mem_read=1 for exactly one cycle. rd_data<=mem_read_data at the end of the cycle; go to RD_HOLD.
  - RD_HOLD: rd_valid=1, rd_data held stable. On rd_ready: if count==0 go to DONE; else cur_addr+1, count-1, go to RD_DRIVE. Otherwise hold indefinitely.
  - DONE: done=1 for one cycle, then IDLE.
- Address increment wraps modulo 2^ADDR_W (7 -> 0). A burst longer than the remaining space wraps and does not error.
- Latency:
  - Single store: request accepted at edge 0; wr_ready high in cycle 1; if wr_valid is high in cycle 1, strobe in cycle 2 and done in cycle 3.
  - Single load: request accepted at edge 0; strobe in cycle 1; rd_valid in cycle 2; with rd_ready=1, done in cycle 3 and req_ready in cycle 4.
- Throughput: 2 cycles per word with no backpressure.
- Invariants:
  - sig_mem_write&&sig_mem_read is never 1.
  - At most one strobe per word.
  - req_ready=0 whenever busy=1; requests during busy are ignored, not queued.

Decomposition:
- Package data_mem_ctrl_pkg holds:
  - state enum (IDLE, WR_WAIT, WR_DRIVE, RD_DRIVE, RD_HOLD, DONE);
  - DATA_W, ADDR_W, LEN_W defaults;
  - MEM_DEPTH = 1<<ADDR_W.
- Single module; the address/count pair is small enough to stay inline, so no sub-module.

Test Plan:
- Reset then single store: addr=3, len=0, wr_data=16'hA5A5 -> exactly one sig_mem_write cycle with mem_addr=3, mem_write_data=A5A5; done 1 cycle later.
- Single load: addr=3 after the store above, rd_ready=1 -> one sig_mem_read cycle; rd_valid with rd_data=A5A5; done the next cycle.
- Wrapping burst store: addr=6, len=3, data 1,2,3,4 with wr_valid gaps -> writes to addresses 6,7,0,1 in order; then burst load addr=6, len=3 returns 1,2,3,4.
- Load backpressure: rd_ready held 0 for 5 cycles -> rd_valid and rd_data stable; no extra sig_mem_read; completes once rd_ready=1.
- Reset mid-burst during WR_WAIT of word 2 -> next cycle IDLE, both strobes 0, done never pulses; a request presented while busy is never accepted.
- Assertion over all tests: sig_mem_write&&sig_mem_read is never 1, and each strobe pulse is exactly 1 cycle.
